// File: rtl/julia_pixel_sequencer.sv
// ---------------------------------------------------------------------------
// julia_pixel_sequencer
//
// Purpose:
//   Computes one Julia-set pixel per job. It runs one iteration per clock by
//   driving an external combinational z_calculator (z^2 + c, |z|^2), applies
//   the bailout test and returns an 8-bit pixel value plus the raw iteration
//   count.
//
// Build option:
//   JULIA_PIXEL_SCALE_EN - when defined, the escaped pixel value is stretched
//   across 0..255 as (k+1)*(256/MAX_ITER)-1. MAX_ITER must then be a power of
//   two no larger than 128. When undefined, the escaped pixel is k+1.
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   flush             - synchronous abort of the job in flight
//   in_valid/in_ready - job handshake; z_*_in and c_*_in are the job operands
//   calc_z_*, calc_c_* - operands presented to the datapath
//   calc_z_*_next     - datapath result z^2 + c
//   calc_size_squared - datapath |z|^2 of the presented z (signed)
//   out_valid/out_ready - result handshake
//   pixel_out         - pixel value
//   iter_count_out    - completed iterations k
//   busy              - high while a job is in ITERATE or DONE
// ---------------------------------------------------------------------------
module julia_pixel_sequencer #(
   parameter int WIDTH      = 20,
   parameter int FRACTIONAL = 10,
   parameter int INTEGRAL   = 10,
   parameter int MAX_ITER   = 16,
   parameter int BAILOUT    = 4 << FRACTIONAL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] z_real_in,
   input  logic [WIDTH-1:0] z_imag_in,
   input  logic [WIDTH-1:0] c_real_in,
   input  logic [WIDTH-1:0] c_imag_in,
   output logic [WIDTH-1:0] calc_z_real,
   output logic [WIDTH-1:0] calc_z_imag,
   output logic [WIDTH-1:0] calc_c_real,
   output logic [WIDTH-1:0] calc_c_imag,
   input  logic [WIDTH-1:0] calc_z_real_next,
   input  logic [WIDTH-1:0] calc_z_imag_next,
   input  logic [WIDTH-1:0] calc_size_squared,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       pixel_out,
   output logic [7:0]       iter_count_out,
   output logic             busy
);

   // Elaboration-time parameter sanity checks.
   if (WIDTH != FRACTIONAL + INTEGRAL) begin : g_bad_width
      $error("WIDTH must equal FRACTIONAL + INTEGRAL");
   end
   if (MAX_ITER < 1 || MAX_ITER > 255) begin : g_bad_max_iter
      $error("MAX_ITER must be in 1..255");
   end

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ITERATE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   localparam logic signed [WIDTH-1:0] bailout_c  = WIDTH'(BAILOUT);
   localparam logic [7:0]              max_iter_c = 8'(MAX_ITER);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] z_real_q, z_real_d;
   logic [WIDTH-1:0] z_imag_q, z_imag_d;
   logic [WIDTH-1:0] c_real_q, c_real_d;
   logic [WIDTH-1:0] c_imag_q, c_imag_d;
   logic [7:0]       iter_q, iter_d;
   logic [7:0]       k_q, k_d;
   logic [7:0]       pixel_q, pixel_d;

   logic             escape;
   logic [7:0]       iter_inc;
   logic [7:0]       escaped_pixel;

   // Escape when |z|^2 exceeds the threshold, or when the datapath result
   // wrapped into the sign bit (|z|^2 can never legitimately be negative).
   assign escape   = ($signed(calc_size_squared) > bailout_c) || calc_size_squared[WIDTH-1];
   assign iter_inc = iter_q + 8'd1;

`ifdef JULIA_PIXEL_SCALE_EN
   if (MAX_ITER > 128 || (MAX_ITER & (MAX_ITER - 1)) != 0) begin : g_bad_scale
      $error("MAX_ITER must be a power of two <= 128 with pixel scaling");
   end

   localparam int scale_shift_c = 8 - $clog2(MAX_ITER);

   // (k+1) << shift reaches 256 at most, so one extra bit holds the product
   // before the -1 brings it back into 8 bits.
   logic [8:0] scaled_pixel;
   assign scaled_pixel  = ({1'b0, iter_inc} << scale_shift_c) - 9'd1;
   assign escaped_pixel = scaled_pixel[7:0];
`else
   assign escaped_pixel = iter_inc;
`endif

   // NOTE: every signal written here gets its default first, so no path
   // through the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      z_real_d = z_real_q;
      z_imag_d = z_imag_q;
      c_real_d = c_real_q;
      c_imag_d = c_imag_q;
      iter_d   = iter_q;
      k_d      = k_q;
      pixel_d  = pixel_q;

      if (flush) begin
         // Abort wins over accept and escape; all job state is left as is.
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  z_real_d = z_real_in;
                  z_imag_d = z_imag_in;
                  c_real_d = c_real_in;
                  c_imag_d = c_imag_in;
                  iter_d   = 8'd0;
                  state_d  = ST_ITERATE;
               end
            end
            ST_ITERATE: begin
               if (escape) begin
                  k_d     = iter_q;
                  pixel_d = escaped_pixel;
                  state_d = ST_DONE;
               end else if (iter_inc == max_iter_c) begin
                  // z is left untouched on the final step: the new value is
                  // never consumed, and keeping it holds calc_* steady in DONE.
                  iter_d  = iter_inc;
                  k_d     = max_iter_c;
                  pixel_d = 8'd0;
                  state_d = ST_DONE;
               end else begin
                  z_real_d = calc_z_real_next;
                  z_imag_d = calc_z_imag_next;
                  iter_d   = iter_inc;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         z_real_q <= '0;
         z_imag_q <= '0;
         c_real_q <= '0;
         c_imag_q <= '0;
         iter_q   <= '0;
         k_q      <= '0;
         pixel_q  <= '0;
      end else begin
         state_q  <= state_d;
         z_real_q <= z_real_d;
         z_imag_q <= z_imag_d;
         c_real_q <= c_real_d;
         c_imag_q <= c_imag_d;
         iter_q   <= iter_d;
         k_q      <= k_d;
         pixel_q  <= pixel_d;
      end
   end

   // z_cur and c_reg only change on accept or while iterating, so the
   // datapath operands naturally hold outside ITERATE.
   assign calc_z_real    = z_real_q;
   assign calc_z_imag    = z_imag_q;
   assign calc_c_real    = c_real_q;
   assign calc_c_imag    = c_imag_q;

   assign in_ready       = (state_q == ST_IDLE);
   assign out_valid      = (state_q == ST_DONE);
   assign busy           = (state_q != ST_IDLE);
   assign pixel_out      = pixel_q;
   assign iter_count_out = k_q;

endmodule

// File: tb/tb_julia_pixel_sequencer.sv
// ---------------------------------------------------------------------------
// tb_julia_pixel_sequencer
//
// Drives julia_pixel_sequencer against a behavioural 20/10/10 z_calculator.
// Expected results are queued when a job is accepted and compared when the
// DUT presents its result.
// ---------------------------------------------------------------------------
module tb_julia_pixel_sequencer;

   localparam int W    = 20;
   localparam int F    = 10;
   localparam int MAXI = 16;

   typedef struct {
      logic [7:0] pix;
      logic [7:0] k;
      int         lat;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst, flush, in_valid, out_ready;
   logic [W-1:0] z_real_in, z_imag_in, c_real_in, c_imag_in;
   logic         in_ready, out_valid, busy;
   logic [W-1:0] calc_z_real, calc_z_imag, calc_c_real, calc_c_imag;
   logic [W-1:0] calc_z_real_next, calc_z_imag_next, calc_size_squared;
   logic [7:0]   pixel_out, iter_count_out;

   bit           stub_ovf = 1'b0;
   exp_t         sb[$];
   int           n_checks = 0;
   int           n_fail   = 0;

   always #5 clk = ~clk;

   julia_pixel_sequencer #(
      .WIDTH(W), .FRACTIONAL(F), .INTEGRAL(W - F), .MAX_ITER(MAXI)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .flush            (flush),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .z_real_in        (z_real_in),
      .z_imag_in        (z_imag_in),
      .c_real_in        (c_real_in),
      .c_imag_in        (c_imag_in),
      .calc_z_real      (calc_z_real),
      .calc_z_imag      (calc_z_imag),
      .calc_c_real      (calc_c_real),
      .calc_c_imag      (calc_c_imag),
      .calc_z_real_next (calc_z_real_next),
      .calc_z_imag_next (calc_z_imag_next),
      .calc_size_squared(calc_size_squared),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .pixel_out        (pixel_out),
      .iter_count_out   (iter_count_out),
      .busy             (busy)
   );

   // Behavioural fixed-point z_calculator; stub_ovf forces a wrapped |z|^2.
   logic signed [2*W-1:0] p_rr, p_ii, p_ri;
   always_comb begin
      p_rr = $signed(calc_z_real) * $signed(calc_z_real);
      p_ii = $signed(calc_z_imag) * $signed(calc_z_imag);
      p_ri = $signed(calc_z_real) * $signed(calc_z_imag);
      calc_z_real_next  = W'((p_rr - p_ii) >>> F) + calc_c_real;
      calc_z_imag_next  = W'((p_ri <<< 1) >>> F) + calc_c_imag;
      calc_size_squared = stub_ovf ? 20'h80000 : W'((p_rr + p_ii) >>> F);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_pix(input int k, input bit esc);
      if (!esc) return 8'd0;
`ifdef JULIA_PIXEL_SCALE_EN
      return 8'((k + 1) * (256 / MAXI) - 1);
`else
      return 8'(k + 1);
`endif
   endfunction

   // Called at a falling edge; returns at the falling edge of cycle 1.
   task automatic accept_job(input logic [W-1:0] zr, input logic [W-1:0] zi,
                             input logic [W-1:0] cr, input logic [W-1:0] ci,
                             input bit push, input int k, input bit esc, input int lat);
      z_real_in = zr;
      z_imag_in = zi;
      c_real_in = cr;
      c_imag_in = ci;
      in_valid  = 1'b1;
      if (push) sb.push_back('{exp_pix(k, esc), 8'(k), lat});
      check("in_ready_pre_accept", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Starts at the falling edge of cycle 1; waits for the result, holds
   // out_ready low for 'hold' cycles, then completes the handshake.
   task automatic wait_out(input int hold, input bit offer_next);
      int   lat = 1;
      exp_t e;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) begin
         check("out_valid_timeout", 32'(out_valid), 32'd1);
         return;
      end
      if (sb.size() == 0) begin
         check("scoreboard_underflow", 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      check("latency", 32'(lat), 32'(e.lat));
      check("pixel_out", 32'(pixel_out), 32'(e.pix));
      check("iter_count_out", 32'(iter_count_out), 32'(e.k));
      check("in_ready_done", 32'(in_ready), 32'd0);
      check("busy_done", 32'(busy), 32'd1);
      if (offer_next) in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_pixel", 32'(pixel_out), 32'(e.pix));
         check("hold_iter_count", 32'(iter_count_out), 32'(e.k));
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("post_hs_out_valid", 32'(out_valid), 32'd0);
      check("post_hs_in_ready", 32'(in_ready), 32'd1);
      check("post_hs_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ov_seen;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      z_real_in = '0;
      z_imag_in = '0;
      c_real_in = '0;
      c_imag_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pixel", 32'(pixel_out), 32'd0);
      check("rst_iter_count", 32'(iter_count_out), 32'd0);
      check("rst_calc_z_real", 32'(calc_z_real), 32'd0);
      check("rst_calc_c_real", 32'(calc_c_real), 32'd0);

      // Inside set: z0 = 0, c = 0
      accept_job(20'h00000, 20'h00000, 20'h00000, 20'h00000, 1, 16, 0, 17);
      wait_out(0, 0);
      // Immediate escape: z0 = 3.0
      accept_job(20'h00C00, 20'h00000, 20'h00000, 20'h00000, 1, 0, 1, 2);
      wait_out(0, 0);
      // Bailout boundary: |z0|^2 = 4.0 keeps iterating, z1 = 4.0 escapes
      accept_job(20'h00800, 20'h00000, 20'h00000, 20'h00000, 1, 1, 1, 3);
      wait_out(0, 0);
      // c = 1.0: z = 0, 1, 2, 5 -> escape after three iterations
      accept_job(20'h00000, 20'h00000, 20'h00400, 20'h00000, 1, 3, 1, 5);
      wait_out(0, 0);
      // c = -1.0: oscillates between 0 and -1, never escapes
      accept_job(20'h00000, 20'h00000, 20'hFFC00, 20'h00000, 1, 16, 0, 17);
      wait_out(0, 0);
      // Overflowed |z|^2 escapes at once
      stub_ovf = 1'b1;
      accept_job(20'h00000, 20'h00000, 20'h00000, 20'h00000, 1, 0, 1, 2);
      wait_out(0, 0);
      stub_ovf = 1'b0;

      // Backpressure with the next job offered during DONE, then back-to-back
      accept_job(20'h00800, 20'h00000, 20'h00000, 20'h00000, 1, 1, 1, 3);
      z_real_in = 20'h00C00;
      wait_out(5, 1);
      accept_job(20'h00C00, 20'h00000, 20'h00000, 20'h00000, 1, 0, 1, 2);
      wait_out(0, 0);

      // Flush together with in_valid in IDLE: job must not be taken
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_idle_busy", 32'(busy), 32'd0);
      check("flush_idle_in_ready", 32'(in_ready), 32'd1);

      // Flush in ITERATE cycle 4
      accept_job(20'h00000, 20'h00000, 20'h00000, 20'h00000, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      check("flush_busy_before", 32'(busy), 32'd1);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      check("flush_in_ready", 32'(in_ready), 32'd1);
      check("flush_busy", 32'(busy), 32'd0);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      ov_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) ov_seen++;
      end
      check("flush_no_result", 32'(ov_seen), 32'd0);

      // Reset in ITERATE cycle 4 (previous result and c_reg are non-zero)
      accept_job(20'h00000, 20'h00000, 20'hFFC00, 20'h00000, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_pixel", 32'(pixel_out), 32'd0);
      check("mid_rst_iter_count", 32'(iter_count_out), 32'd0);
      check("mid_rst_calc_z_real", 32'(calc_z_real), 32'd0);
      check("mid_rst_calc_c_real", 32'(calc_c_real), 32'd0);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
